// File: rtl/jtag_scan_registers.sv
// IR plus BYPASS/IDCODE/USER data registers driven by the registered TAP state.
// Capture/shift/update happen on posedge tck; tdo is launched on negedge tck.
module jtag_scan_registers #(
    parameter int                  IR_WIDTH  = 5,
    parameter int                  DR_WIDTH  = 32,
    parameter logic [31:0]         IDCODE    = 32'h1000_0A3F,
    parameter logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(2)
) (
    input  logic                tck,
    input  logic                rst,
    input  logic [3:0]          state,
    input  logic                tdi,
    input  logic [DR_WIDTH-1:0] user_cap,
    output logic                tdo,
    output logic                tdo_en,
    output logic [IR_WIDTH-1:0] ir_value,
    output logic [DR_WIDTH-1:0] user_out,
    output logic                user_update
);

    // TAP state codes as produced by the TAP controller
    localparam logic [3:0] STATE_TEST_LOGIC_RESET = 4'd0;
    localparam logic [3:0] STATE_RUN_TEST_IDLE    = 4'd1;
    localparam logic [3:0] STATE_SELECT_DR        = 4'd2;
    localparam logic [3:0] STATE_CAPTURE_DR       = 4'd3;
    localparam logic [3:0] STATE_SHIFT_DR         = 4'd4;
    localparam logic [3:0] STATE_EXIT1_DR         = 4'd5;
    localparam logic [3:0] STATE_PAUSE_DR         = 4'd6;
    localparam logic [3:0] STATE_EXIT2_DR         = 4'd7;
    localparam logic [3:0] STATE_UPDATE_DR        = 4'd8;
    localparam logic [3:0] STATE_SELECT_IR        = 4'd9;
    localparam logic [3:0] STATE_CAPTURE_IR       = 4'd10;
    localparam logic [3:0] STATE_SHIFT_IR         = 4'd11;
    localparam logic [3:0] STATE_EXIT1_IR         = 4'd12;
    localparam logic [3:0] STATE_PAUSE_IR         = 4'd13;
    localparam logic [3:0] STATE_EXIT2_IR         = 4'd14;
    localparam logic [3:0] STATE_UPDATE_IR        = 4'd15;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass_reg;
    logic [31:0]         idcode_reg;
    logic [DR_WIDTH-1:0] user_shift;

    logic sel_idcode;
    logic sel_user;
    logic dr_bit0;

    // DR selection depends only on the active instruction, so it is stable
    // for the whole DR scan.
    always_comb begin
        sel_idcode = 1'b0;
        sel_user   = 1'b0;
        if (ir_value == IR_IDCODE) begin
            sel_idcode = 1'b1;
        end else if (ir_value == IR_USER) begin
            sel_user = 1'b1;
        end
    end

    always_comb begin
        dr_bit0 = bypass_reg;
        if (sel_idcode) begin
            dr_bit0 = idcode_reg[0];
        end else if (sel_user) begin
            dr_bit0 = user_shift[0];
        end
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            ir_shift <= '0;
            ir_value <= IR_IDCODE;
        end else begin
            case (state)
                STATE_TEST_LOGIC_RESET: ir_value <= IR_IDCODE;
                STATE_CAPTURE_IR:       ir_shift <= IR_CAPTURE;
                STATE_SHIFT_IR:         ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                STATE_UPDATE_IR:        ir_value <= ir_shift;
                default: ;
            endcase
        end
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            bypass_reg <= 1'b0;
            idcode_reg <= '0;
            user_shift <= '0;
        end else begin
            case (state)
                STATE_CAPTURE_DR: begin
                    if (sel_idcode) begin
                        idcode_reg <= IDCODE;
                    end else if (sel_user) begin
                        user_shift <= user_cap;
                    end else begin
                        bypass_reg <= 1'b0;
                    end
                end
                STATE_SHIFT_DR: begin
                    if (sel_idcode) begin
                        idcode_reg <= {tdi, idcode_reg[31:1]};
                    end else if (sel_user) begin
                        user_shift <= {tdi, user_shift[DR_WIDTH-1:1]};
                    end else begin
                        bypass_reg <= tdi;
                    end
                end
                default: ;
            endcase
        end
    end

    // user_update is a single-tck strobe; it self-clears on the following edge.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            user_out    <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (state == STATE_UPDATE_DR && sel_user) begin
                user_out    <= user_shift;
                user_update <= 1'b1;
            end
        end
    end

    // Falling-edge launch gives the downstream device a half cycle of setup.
    always_ff @(negedge tck or posedge rst) begin
        if (rst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (state == STATE_SHIFT_IR) begin
            tdo    <= ir_shift[0];
            tdo_en <= 1'b1;
        end else if (state == STATE_SHIFT_DR) begin
            tdo    <= dr_bit0;
            tdo_en <= 1'b1;
        end else begin
            tdo_en <= 1'b0;
        end
    end

endmodule
